wvb_hdr_rr_arb: RTL



---
 rtl/wvb_hdr_rr_arb.sv | 117 +++++++++++
 1 files changed

// File: rtl/wvb_hdr_rr_arb.sv
// Round-robin grant of per-channel waveform headers onto the shared readout path.
// Latency: rd_valid rises 1 cycle after hdr_rdy is sampled in IDLE; hdr_ack pops 1 cycle after rd_ack.
// Backpressure: header is held on rd_valid until rd_ack; grant is held until rd_done or timeout.
module wvb_hdr_rr_arb #(
    parameter int              N_CHAN  = 24,
    parameter int              HDR_W   = 102,
    parameter int              IDX_W   = 5,
    parameter int              TO_W    = 16,
    parameter logic [TO_W-1:0] TIMEOUT = 16'd50000
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic [N_CHAN-1:0]       hdr_rdy,
    input  logic [N_CHAN*HDR_W-1:0] hdr_bundles,
    output logic [N_CHAN-1:0]       hdr_ack,
    output logic                    rd_valid,
    output logic [HDR_W-1:0]        rd_hdr,
    output logic [IDX_W-1:0]        rd_chan,
    input  logic                    rd_ack,
    input  logic                    rd_done,
    output logic                    busy,
    output logic                    timeout_err
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_PRESENT = 2'd1;
    localparam logic [1:0] S_WAIT    = 2'd2;

    logic [1:0]          state;
    logic [IDX_W-1:0]    ptr;
    logic [TO_W-1:0]     count;

    logic [HDR_W-1:0]    hdr_arr [N_CHAN];
    logic [2*N_CHAN-1:0] rdy_dbl;
    logic [N_CHAN-1:0]   rdy_rot;
    logic                gnt_found;
    logic [IDX_W:0]      gnt_sum;
    logic [IDX_W-1:0]    gnt_idx;
    logic [IDX_W-1:0]    ptr_next;
    logic [N_CHAN-1:0]   ack_onehot;

    for (genvar gi = 0; gi < N_CHAN; gi++) begin : g_unpack
        assign hdr_arr[gi] = hdr_bundles[gi*HDR_W +: HDR_W];
    end

    // Rotate so bit 0 is the channel at ptr; the first set bit is the grant offset.
    assign rdy_dbl = {hdr_rdy, hdr_rdy};
    assign rdy_rot = N_CHAN'(rdy_dbl >> ptr);

    always_comb begin
        gnt_found = 1'b0;
        gnt_sum   = '0;
        for (int k = 0; k < N_CHAN; k++) begin
            if (!gnt_found && rdy_rot[k]) begin
                gnt_found = 1'b1;
                gnt_sum   = {1'b0, ptr} + (IDX_W+1)'(k);
            end
        end
        if (gnt_sum >= (IDX_W+1)'(N_CHAN)) begin
            gnt_sum = gnt_sum - (IDX_W+1)'(N_CHAN);
        end
        gnt_idx = gnt_sum[IDX_W-1:0];
    end

    assign ptr_next   = (rd_chan == IDX_W'(N_CHAN-1)) ? '0 : rd_chan + IDX_W'(1);
    assign ack_onehot = {{(N_CHAN-1){1'b0}}, 1'b1} << rd_chan;
    assign busy       = (state == S_PRESENT) || (state == S_WAIT);

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            ptr         <= '0;
            count       <= '0;
            rd_valid    <= 1'b0;
            rd_hdr      <= '0;
            rd_chan     <= '0;
            hdr_ack     <= '0;
            timeout_err <= 1'b0;
        end else begin
            hdr_ack     <= '0;
            timeout_err <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (en && gnt_found) begin
                        rd_chan  <= gnt_idx;
                        rd_hdr   <= hdr_arr[gnt_idx];
                        rd_valid <= 1'b1;
                        state    <= S_PRESENT;
                    end
                end
                S_PRESENT: begin
                    if (rd_ack) begin
                        hdr_ack  <= ack_onehot;
                        rd_valid <= 1'b0;
                        count    <= '0;
                        state    <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    count <= count + TO_W'(1);
                    // A completion landing on the timeout cycle wins over the abort.
                    if (rd_done) begin
                        ptr   <= ptr_next;
                        state <= S_IDLE;
                    end else if ((TIMEOUT != '0) && (count == TIMEOUT - TO_W'(1))) begin
                        timeout_err <= 1'b1;
                        ptr         <= ptr_next;
                        state       <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
